// File: rtl/spram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM access controller.
package spram_ctrl_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_LEN_W      = 4;
  localparam int RSP_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    RD_DRAIN
  } state_t;

endpackage

// File: rtl/spram_rsp_fifo.sv
// Two-entry in-order response FIFO. A push and a pop in the same cycle are
// legal even when full, because the head is read before the slot is reused.
module spram_rsp_fifo
  import spram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [RSP_FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the occupancy counter alone decides
    // which entries are meaningful.
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/spram_access_ctrl.sv
// Request-side controller for single_port_ram: command/write/response
// handshakes, burst sequencing with address wrap, read-latency alignment.
// Optional feature: define SPRAM_BURST_EN to honour cmd_len (multi-beat
// bursts); without it every command is one beat and no beat counter exists.
module spram_access_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              inflight;   // a read issued last cycle, data on ram_q now
  logic [1:0]        fifo_count;
  logic              fifo_pop;
  logic              cmd_accept;
  logic              wr_beat;
  logic              rd_issue;
  logic              last_beat;
  logic [2:0]        occ;

  // Handshakes, credit-gated read issue and RAM pin drive. Outputs are
  // gated by rst_n so they read as idle during reset, before the first edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned and infers a latch.
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_data  = '0;
    ram_addr  = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    rd_issue  = 1'b0;
    // Occupancy seen by the next push; a pop this cycle frees its slot in
    // time, which keeps back-to-back reads at one per cycle.
    occ = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, fifo_pop};
    if (rst_n) begin
      cmd_ready = (state == IDLE);
      wr_ready  = (state == WR_BURST);
      ram_we    = wr_ready && wr_valid;
      ram_data  = ram_we ? wr_data : '0;
      ram_addr  = addr_cnt;
      rsp_valid = (fifo_count != 2'd0);
      busy      = (state != IDLE) || (fifo_count != 2'd0);
      rd_issue  = (state == RD_BURST) && (occ < 3'(RSP_FIFO_DEPTH));
    end
  end

  assign cmd_accept = cmd_valid && cmd_ready;
  assign wr_beat    = ram_we;
  assign fifo_pop   = rsp_valid && rsp_ready;

`ifdef SPRAM_BURST_EN
  logic [LEN_W-1:0] beat_cnt;

  // Remaining beats after the current one; reloaded on command accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (cmd_accept) begin
      beat_cnt <= cmd_len;
    end else if (wr_beat || rd_issue) begin
      beat_cnt <= beat_cnt - LEN_W'(1);
    end
  end

  assign last_beat = (beat_cnt == '0);
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign last_beat  = 1'b1;
`endif

  // Burst FSM with address counter and read-in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            addr_cnt <= cmd_addr;
            state    <= cmd_we ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST: begin
          if (wr_beat) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (last_beat) state <= IDLE;
          end
        end
        RD_BURST: begin
          if (rd_issue) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (last_beat) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (!inflight && fifo_count == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  spram_rsp_fifo #(.DATA_W(DATA_W)) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_q),
    .pop       (fifo_pop),
    .pop_data  (rsp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Self-checking bench for spram_access_ctrl with a behavioural single-port
// RAM, a write/response scoreboard and a table of single-beat commands.
module tb_spram_access_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic              busy;

  always #5 clk = ~clk;

  spram_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  // Single-port RAM: address registered, q follows one cycle later.
  logic [DATA_W-1:0] mem [64];
  logic [ADDR_W-1:0] addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;   // write data, or expected read data
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] rsp_q [$];
  wr_t               wq [$];
  logic [DATA_W-1:0] shadow [64];
  logic [DATA_W-1:0] bdat [16];
  vec_t              vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbeats(input logic [LEN_W-1:0] l);
`ifdef SPRAM_BURST_EN
    return int'(l) + 1;
`else
    return 1;
`endif
  endfunction

  // Scoreboard: RAM writes and delivered responses, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    wr_t               we_e;
    logic [DATA_W-1:0] re_e;
    if (!rst_n) begin
      check("rst_ram_we", ram_we, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cmd_ready", cmd_ready, 0);
    end else begin
      if (ram_we) begin
        if (wq.size() == 0) begin
          check("unexpected_ram_we", ram_we, 0);
        end else begin
          we_e = wq.pop_front();
          check("wr_addr", ram_addr, we_e.a);
          check("wr_data", ram_data, we_e.d);
        end
      end else if (!wr_ready) begin
        check("idle_ram_data", ram_data, 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          re_e = rsp_q.pop_front();
          check("rsp_data", rsp_data, re_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command; returns at posedge+1 of the cycle after acceptance.
  task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int t;
    t = 0;
    cmd_we = we; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Drive n write beats from bdat, with gap_len idle cycles before beat gap_idx.
  task automatic send_beats(input logic [ADDR_W-1:0] a, input int n, input int gap_idx, input int gap_len);
    wr_t e;
    int  t;
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx) repeat (gap_len) tick();
      e.a = a + ADDR_W'(i);
      e.d = bdat[i];
      wq.push_back(e);
      shadow[e.a] = e.d;
      wr_valid = 1'b1;
      wr_data  = bdat[i];
      t = 0;
      @(negedge clk);
      while (!wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("wr_ready", wr_ready, 1);
      tick();
      wr_valid = 1'b0;
    end
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input int gap_idx, input int gap_len);
    send_cmd(1'b1, a, l);
    send_beats(a, nbeats(l), gap_idx, gap_len);
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    for (int i = 0; i < nbeats(l); i++) rsp_q.push_back(shadow[a + ADDR_W'(i)]);
    send_cmd(1'b0, a, l);
  endtask

  // Wait (bounded) until the controller is idle and all expectations consumed.
  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || rsp_q.size() != 0 || wq.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy"}, busy, 0);
    check({name, "_rsp_left"}, rsp_q.size(), 0);
    check({name, "_wr_left"}, wq.size(), 0);
    check({name, "_cmd_ready"}, cmd_ready, 1);
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int gap;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    tick();

    // Single-beat command table.
    vt[0]  = '{1'b1, 6'd0,  8'h01};
    vt[1]  = '{1'b1, 6'd1,  8'h02};
    vt[2]  = '{1'b1, 6'd2,  8'h03};
    vt[3]  = '{1'b0, 6'd0,  8'h01};
    vt[4]  = '{1'b0, 6'd1,  8'h02};
    vt[5]  = '{1'b0, 6'd2,  8'h03};
    vt[6]  = '{1'b1, 6'd63, 8'hFF};
    vt[7]  = '{1'b1, 6'd32, 8'h5A};
    vt[8]  = '{1'b0, 6'd63, 8'hFF};
    vt[9]  = '{1'b0, 6'd32, 8'h5A};
    vt[10] = '{1'b0, 6'd0,  8'h01};
    for (int i = 0; i < 11; i++) begin
      if (vt[i].we) begin
        bdat[0] = vt[i].data;
        write_burst(vt[i].addr, '0, -1, 0);
        wait_idle("tbl_wr");
      end else begin
        rsp_q.push_back(vt[i].data);
        send_cmd(1'b0, vt[i].addr, '0);
        // Issue in this cycle; rsp_valid two cycles later.
        @(negedge clk); check("lat_issue", rsp_valid, 0);
        @(negedge clk); check("lat_q", rsp_valid, 0);
        @(negedge clk); check("lat_rsp", rsp_valid, 1);
        wait_idle("tbl_rd");
      end
    end

    // Burst write wrapping past the top address, then read back.
    bdat[0] = 8'hAA; bdat[1] = 8'hBB; bdat[2] = 8'hCC; bdat[3] = 8'hDD;
    write_burst(6'd62, 4'd3, -1, 0);
    wait_idle("wrap_wr");
    read_burst(6'd62, 4'd3);
    wait_idle("wrap_rd");

    // Long read burst against a stalled response channel.
    for (int i = 0; i < 16; i++) bdat[i] = 8'h30 + 8'(i);
    write_burst(6'd10, 4'd7, -1, 0);
    wait_idle("stall_wr");
    rsp_ready = 1'b0;
    read_burst(6'd10, 4'd7);
    repeat (5) tick();
    check("stall_valid", rsp_valid, 1);
    check("stall_head", rsp_data, 8'h30);
    check("stall_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_idle("stall_rd");

    // Write burst with wr_valid dropped for two cycles.
    bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33; bdat[3] = 8'h44;
    gap = (nbeats(4'd3) > 2) ? 2 : 0;
    write_burst(6'd20, 4'd3, gap, 2);
    wait_idle("gap_wr");
    read_burst(6'd20, 4'd3);
    wait_idle("gap_rd");

    // Reset in the middle of a read burst.
    rsp_ready = 1'b0;
    read_burst(6'd10, 4'd7);
    tick();
    tick();
    rsp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_rsp_valid", rsp_valid, 0);
    check("rel_busy", busy, 0);
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rel_flushed", rsp_valid, 0);
    end
    tick();

    // Read with cmd_len=5: beat count depends on the burst build option.
    read_burst(6'd10, 4'd5);
    wait_idle("len5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
